// File: rtl/booth_seq_multiplier.sv
// Sequential signed radix-2 Booth multiplier.
// Spends one clock per operand bit. The product register holds the last
// completed result so the ALU result selector can sample it at any time.
module booth_seq_multiplier #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   mul_answer
);

    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned ACC_W  = WIDTH + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    // Control state
    logic [1:0]        state;
    logic [1:0]        state_n;
    logic              busy_n;
    logic              done_n;

    // Datapath registers: {acc, q_reg, q_m1} is the Booth shift chain
    logic [WIDTH-1:0]  m_reg;
    logic [WIDTH-1:0]  m_n;
    logic [WIDTH-1:0]  q_reg;
    logic [WIDTH-1:0]  q_n;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_n;
    logic              q_m1;
    logic              q_m1_n;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_n;
    logic [PROD_W-1:0] answer_n;

    // Booth step results
    logic [ACC_W-1:0]  m_ext;
    logic [ACC_W-1:0]  step_sum;
    logic [ACC_W-1:0]  sh_acc;
    logic [WIDTH-1:0]  sh_q;
    logic              load_c;

    // Operands are accepted only when no iteration is in progress
    assign load_c = start && ((state == IDLE) || (state == DONE));

    // One Booth add/subtract followed by the arithmetic right shift
    always_comb begin
        m_ext = {m_reg[WIDTH-1], m_reg};
        unique case ({q_reg[0], q_m1})
            2'b01:   step_sum = acc + m_ext;
            2'b10:   step_sum = acc - m_ext;
            default: step_sum = acc;
        endcase
        sh_acc = {step_sum[ACC_W-1], step_sum[ACC_W-1:1]};
        sh_q   = {step_sum[0], q_reg[WIDTH-1:1]};
    end

    // Next-state and next-datapath logic
    always_comb begin
        state_n  = state;
        m_n      = m_reg;
        q_n      = q_reg;
        acc_n    = acc;
        q_m1_n   = q_m1;
        cnt_n    = cnt;
        answer_n = mul_answer;
        busy_n   = 1'b0;
        done_n   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (load_c) begin
                    state_n = CALC;
                    m_n     = a;
                    q_n     = b;
                    acc_n   = '0;
                    q_m1_n  = 1'b0;
                    cnt_n   = '0;
                end
            end
            CALC: begin
                acc_n  = sh_acc;
                q_n    = sh_q;
                q_m1_n = q_reg[0];
                cnt_n  = cnt + CNT_W'(1);
                if (cnt == LAST_STEP) begin
                    state_n  = DONE;
                    // The full product always fits in the low 2*WIDTH bits
                    answer_n = {sh_acc[WIDTH-1:0], sh_q};
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n == CALC);
        done_n = (state_n == DONE);
    end

    // State register with registered status decodes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            busy  <= busy_n;
            done  <= done_n;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_reg      <= '0;
            q_reg      <= '0;
            acc        <= '0;
            q_m1       <= 1'b0;
            cnt        <= '0;
            mul_answer <= '0;
        end else begin
            m_reg      <= m_n;
            q_reg      <= q_n;
            acc        <= acc_n;
            q_m1       <= q_m1_n;
            cnt        <= cnt_n;
            mul_answer <= answer_n;
        end
    end

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: timeline/arithmetic model
// checked every cycle, plus directed vectors with literal expectations.
module tb_booth_seq_multiplier;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned PW    = 2 * WIDTH;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [WIDTH-1:0]  a = '0;
    logic [WIDTH-1:0]  b = '0;
    logic              busy;
    logic              done;
    logic [PW-1:0]     mul_answer;

    int n_checks = 0;
    int n_fails  = 0;
    bit chk_en   = 1'b0;

    booth_seq_multiplier #(.WIDTH(WIDTH), .CNT_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .mul_answer (mul_answer)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an accepted start makes the unit busy for WIDTH cycles, then
    // done for one cycle with the signed product of the captured operands.
    logic signed [WIDTH-1:0] pa = '0;
    logic signed [WIDTH-1:0] pb = '0;
    int                      op_left = 0;
    logic                    exp_done = 1'b0;
    logic signed [PW-1:0]    exp_ans = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            op_left  <= 0;
            exp_done <= 1'b0;
            exp_ans  <= '0;
        end else if (op_left == 0 && start) begin
            pa       <= $signed(a);
            pb       <= $signed(b);
            op_left  <= WIDTH;
            exp_done <= 1'b0;
        end else if (op_left != 0) begin
            op_left  <= op_left - 1;
            exp_done <= (op_left == 1);
            if (op_left == 1) exp_ans <= pa * pb;
        end else begin
            exp_done <= 1'b0;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", PW'(busy), PW'(op_left != 0));
            check("cyc_done", PW'(done), PW'(exp_done));
            check("cyc_answer", mul_answer, exp_ans);
        end
    end

    // Issue one operation from the current negedge and wait for done.
    // glitch_at > 0 re-pulses start with other operands mid-calculation.
    task automatic do_op(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic [PW-1:0] expv, input int glitch_at);
        int n;
        bit got;
        a = av;
        b = bv;
        start = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (glitch_at > 0 && n == glitch_at) begin
                a = 8'd9;
                b = 8'd9;
                start = 1'b1;
            end
            if (done) got = 1'b1;
        end
        start = 1'b0;
        if (!got) begin
            n_checks++;
            n_fails++;
            $display("FAIL op_timeout: no done within %0d cycles", n);
        end else begin
            check("latency", PW'(n), PW'(WIDTH + 1));
            check("product", mul_answer, expv);
        end
    endtask

    logic [WIDTH-1:0] vals [16];
    logic signed [PW-1:0] ref_p;

    initial begin
        vals[0]  = 8'h00; vals[1]  = 8'h01; vals[2]  = 8'h02; vals[3]  = 8'h03;
        vals[4]  = 8'hFF; vals[5]  = 8'hFE; vals[6]  = 8'h7F; vals[7]  = 8'h7E;
        vals[8]  = 8'h80; vals[9]  = 8'h81; vals[10] = 8'h55; vals[11] = 8'hAA;
        vals[12] = 8'h07; vals[13] = 8'hF9; vals[14] = 8'h40; vals[15] = 8'hC0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", PW'(busy), '0);
        check("rst_done", PW'(done), '0);
        check("rst_answer", mul_answer, '0);
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // Directed vectors
        do_op(8'd7, 8'd6, 16'h002A, 0);
        @(negedge clk);
        check("after_busy", PW'(busy), '0);
        check("after_done", PW'(done), '0);
        check("hold_answer", mul_answer, 16'h002A);
        do_op(8'hFD, 8'd5, 16'hFFF1, 0);
        do_op(8'h00, 8'h80, 16'h0000, 0);
        do_op(8'h80, 8'h80, 16'h4000, 0);
        do_op(8'h80, 8'h7F, 16'hC080, 0);
        @(negedge clk);
        // Start re-pulsed mid-calculation is ignored
        do_op(8'd2, 8'd3, 16'h0006, 3);
        // Back-to-back: start during the done cycle
        do_op(8'hFF, 8'hFF, 16'h0001, 0);

        // Asynchronous reset mid-calculation
        @(negedge clk);
        do_op(8'd7, 8'd6, 16'h002A, 0);
        a = 8'd5;
        b = 8'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("pre_rst_busy", PW'(busy), PW'(1));
        check("pre_rst_answer", mul_answer, 16'h002A);
        #2 rst = 1'b1;
        #1;
        check("async_busy", PW'(busy), '0);
        check("async_done", PW'(done), '0);
        check("async_answer", mul_answer, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("post_rst_busy", PW'(busy), '0);
        check("post_rst_answer", mul_answer, '0);

        // Cross product of boundary values, back-to-back
        foreach (vals[i]) begin
            foreach (vals[j]) begin
                ref_p = $signed(vals[i]) * $signed(vals[j]);
                do_op(vals[i], vals[j], ref_p, 0);
            end
        end

        // Random operands with idle gaps
        for (int k = 0; k < 300; k++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom_range(0, 255));
            rb = WIDTH'($urandom_range(0, 255));
            ref_p = $signed(ra) * $signed(rb);
            if (k % 3 == 0) @(negedge clk);
            do_op(ra, rb, ref_p, 0);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
